// File: rtl/irq_ctl_if.sv
// rtl/irq_ctl_if.sv - interrupt controller source, core handshake and config bus bundle
interface irq_ctl_if #(
  parameter int NSRC  = 8,
  parameter int VEC_W = 3
);
  logic [NSRC-1:0]  irq_src;
  logic             iack;
  logic             irq;
  logic [VEC_W-1:0] irq_vec;
  logic             in_service;
  logic             cfg_wr;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_din;
  logic [31:0]      cfg_dout;

  modport master (
    output irq_src, iack, cfg_wr, cfg_addr, cfg_din,
    input  irq, irq_vec, in_service, cfg_dout
  );

  modport slave (
    input  irq_src, iack, cfg_wr, cfg_addr, cfg_din,
    output irq, irq_vec, in_service, cfg_dout
  );
endinterface

// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - edge-detecting, fixed-priority interrupt controller with iack handshake
module irq_ctl #(
  parameter int NSRC  = 8,
  parameter int VEC_W = 3
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  irq_ctl_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERV, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [NSRC-1:0]  src_q;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic [NSRC-1:0]  mask_q, mask_d;
  logic             en_q, en_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             spur_q, spur_d;

  logic [NSRC-1:0]  edge_w, elig_w, low_oh_w, ack_clr_w, w1c_w;
  logic [VEC_W-1:0] low_idx_w;
  logic             unused_din_w;

  assign edge_w   = bus.irq_src & ~src_q;
  assign elig_w   = pend_q & mask_q & {NSRC{en_q}};
  assign low_oh_w = elig_w & (~elig_w + 1'b1);
  assign w1c_w    = (bus.cfg_wr && bus.cfg_addr == 2'd1) ? bus.cfg_din[NSRC-1:0] : '0;
  assign unused_din_w = ^bus.cfg_din;

  always_comb begin
    low_idx_w = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig_w[i]) low_idx_w = VEC_W'(i);
    end
  end

  // An iack seen outside REQ is served as spurious so the core handshake still completes.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    spur_d    = spur_q;
    ack_clr_w = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.iack) begin
          state_d = S_SERV;
          vec_d   = '1;
          spur_d  = 1'b1;
        end else if (|elig_w) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.iack) begin
          state_d = S_SERV;
          if (|elig_w) begin
            vec_d     = low_idx_w;
            spur_d    = 1'b0;
            ack_clr_w = low_oh_w;
          end else begin
            vec_d  = '1;
            spur_d = 1'b1;
          end
        end
      end
      S_SERV:  if (!bus.iack) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A new edge on the same cycle as a clear keeps the bit set.
  assign pend_d = (pend_q & ~w1c_w & ~ack_clr_w) | edge_w;
  assign mask_d = (bus.cfg_wr && bus.cfg_addr == 2'd0) ? bus.cfg_din[NSRC-1:0] : mask_q;
  assign en_d   = (bus.cfg_wr && bus.cfg_addr == 2'd3) ? bus.cfg_din[0] : en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      en_q    <= 1'b0;
      vec_q   <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= bus.irq_src;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      vec_q   <= vec_d;
      spur_q  <= spur_d;
    end
  end

  assign bus.irq        = (state_q == S_REQ);
  assign bus.in_service = (state_q == S_SERV);
  assign bus.irq_vec    = vec_q;

  always_comb begin
    bus.cfg_dout = '0;
    case (bus.cfg_addr)
      2'd0: bus.cfg_dout[NSRC-1:0] = mask_q;
      2'd1: bus.cfg_dout[NSRC-1:0] = pend_q;
      2'd2: begin
        bus.cfg_dout[VEC_W-1:0] = vec_q;
        bus.cfg_dout[8]         = spur_q;
        bus.cfg_dout[9]         = (state_q == S_SERV);
      end
      2'd3: bus.cfg_dout[0] = en_q;
    endcase
  end
endmodule
